matrix_acc: RTL and testbench

- Downstream consumer of the 3x3 constant-matrix multiplier stage.
- Takes its three 10-bit product outputs (mo0..mo2) as a vector stream with a valid/ready handshake.
- Accumulates LEN consecutive accepted vectors per lane and presents the three sums as one frame result with a valid/ready output handshake.
- Provides the windowed sum that feeds the next processing stage.

---
 rtl/matrix_acc.sv | 90 +++++++++
 tb/tb_matrix_acc.sv | 202 ++++++++++++++++++++
 2 files changed

// File: rtl/matrix_acc.sv
// Frame accumulator behind the 3x3 constant-matrix multiplier: sums LEN accepted
// product vectors per lane and hands the three sums downstream as one frame.
//
// state | meaning
// ACC   | accepting vectors, accumulating towards LEN samples
// HOLD  | frame sum presented on so0..so2, waiting for out_ready
module matrix_acc #(
   parameter int LEN   = 8,
   parameter int ACC_W = 13
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [9:0]       mi0,
   input  logic [9:0]       mi1,
   input  logic [9:0]       mi2,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [ACC_W-1:0] so0,
   output logic [ACC_W-1:0] so1,
   output logic [ACC_W-1:0] so2,
   output logic [7:0]       frame_cnt
);

   typedef enum logic {ACC, HOLD} state_t;

   localparam logic [7:0] LAST = 8'(LEN - 1);

   state_t           state, state_nx;
   logic [7:0]       cnt;
   logic [ACC_W-1:0] acc0, acc1, acc2;
   logic             accept;
   logic             last;
   logic             handoff;

   assign in_ready  = (state == ACC) && !reset;
   assign out_valid = (state == HOLD);
   assign accept    = in_valid && in_ready;
   assign last      = accept && (cnt == LAST);
   assign handoff   = out_valid && out_ready;

   always_ff @(posedge clk) begin
      if (reset) state <= ACC;
      else       state <= state_nx;
   end

   always_comb begin
      state_nx = state;
      case (state)
         ACC:     if (last)    state_nx = HOLD;
         HOLD:    if (handoff) state_nx = ACC;
         default: state_nx = ACC;
      endcase
   end

   // The completing sample is folded straight into so_k so the accumulators
   // can clear in the same edge and the result appears one cycle later.
   always_ff @(posedge clk) begin
      if (reset) begin
         cnt       <= '0;
         acc0      <= '0;
         acc1      <= '0;
         acc2      <= '0;
         so0       <= '0;
         so1       <= '0;
         so2       <= '0;
         frame_cnt <= '0;
      end else begin
         if (accept) begin
            if (last) begin
               so0  <= acc0 + ACC_W'(mi0);
               so1  <= acc1 + ACC_W'(mi1);
               so2  <= acc2 + ACC_W'(mi2);
               acc0 <= '0;
               acc1 <= '0;
               acc2 <= '0;
               cnt  <= '0;
            end else begin
               acc0 <= acc0 + ACC_W'(mi0);
               acc1 <= acc1 + ACC_W'(mi1);
               acc2 <= acc2 + ACC_W'(mi2);
               cnt  <= cnt + 8'd1;
            end
         end
         if (handoff) frame_cnt <= frame_cnt + 8'd1;
      end
   end

endmodule

// File: tb/tb_matrix_acc.sv
// Directed bench for matrix_acc: one LEN=8 instance for frame/backpressure/gap
// cases and one LEN=1 instance for single-vector frames and frame_cnt wrap.
module tb_matrix_acc;

   logic        clk = 1'b0;
   always #5 clk = ~clk;

   logic        reset, in_valid, out_ready;
   logic [9:0]  mi0, mi1, mi2;
   logic        in_ready, out_valid;
   logic [12:0] so0, so1, so2;
   logic [7:0]  frame_cnt;

   logic        reset1, in_valid1, out_ready1;
   logic [9:0]  mj0, mj1, mj2;
   logic        in_ready1, out_valid1;
   logic [12:0] sp0, sp1, sp2;
   logic [7:0]  frame_cnt1;

   int n_vec = 0;
   int n_err = 0;

   matrix_acc #(.LEN(8), .ACC_W(13)) dut (
      .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
      .mi0(mi0), .mi1(mi1), .mi2(mi2), .out_valid(out_valid), .out_ready(out_ready),
      .so0(so0), .so1(so1), .so2(so2), .frame_cnt(frame_cnt)
   );

   matrix_acc #(.LEN(1), .ACC_W(13)) dut1 (
      .clk(clk), .reset(reset1), .in_valid(in_valid1), .in_ready(in_ready1),
      .mi0(mj0), .mi1(mj1), .mi2(mj2), .out_valid(out_valid1), .out_ready(out_ready1),
      .so0(sp0), .so1(sp1), .so2(sp2), .frame_cnt(frame_cnt1)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_vec++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk_sums(input string tag, input int e0, input int e1, input int e2);
      chk({tag, ".so0"}, 32'(so0), e0);
      chk({tag, ".so1"}, 32'(so1), e1);
      chk({tag, ".so2"}, 32'(so2), e2);
   endtask

   // n accepted vectors back to back on the LEN=8 instance
   task automatic send(input int n, input int a, input int b, input int c);
      for (int i = 0; i < n; i++) begin
         in_valid = 1'b1;
         mi0 = 10'(a); mi1 = 10'(b); mi2 = 10'(c);
         tick();
      end
      in_valid = 1'b0;
   endtask

   task automatic handshake();
      out_ready = 1'b1;
      tick();
      out_ready = 1'b0;
   endtask

   initial begin
      reset = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
      mi0 = '0; mi1 = '0; mi2 = '0;
      reset1 = 1'b1; in_valid1 = 1'b0; out_ready1 = 1'b0;
      mj0 = '0; mj1 = '0; mj2 = '0;
      tick();
      tick();
      chk("rst.in_ready", 32'(in_ready), 0);
      chk("rst.out_valid", 32'(out_valid), 0);
      chk("rst.frame_cnt", 32'(frame_cnt), 0);
      chk_sums("rst", 0, 0, 0);
      reset = 1'b0;
      reset1 = 1'b0;
      #1;
      chk("idle.in_ready", 32'(in_ready), 1);

      // basic frame
      send(7, 25, 31, 25);
      chk("basic.early_valid", 32'(out_valid), 0);
      send(1, 25, 31, 25);
      chk("basic.out_valid", 32'(out_valid), 1);
      chk("basic.in_ready", 32'(in_ready), 0);
      chk_sums("basic", 200, 248, 200);
      handshake();
      chk("basic.frame_cnt", 32'(frame_cnt), 1);
      chk("basic.out_valid_drop", 32'(out_valid), 0);
      chk("basic.in_ready_back", 32'(in_ready), 1);
      chk_sums("basic.kept", 200, 248, 200);

      // maximum values
      send(8, 375, 495, 375);
      chk_sums("max", 3000, 3960, 3000);
      handshake();

      // mixed vectors
      send(4, 0, 0, 0);
      send(4, 105, 195, 105);
      chk_sums("mixed", 420, 780, 420);
      chk("mixed.frame_cnt", 32'(frame_cnt), 2);

      // backpressure: inputs in HOLD must be ignored
      for (int i = 0; i < 5; i++) begin
         in_valid = 1'b1;
         mi0 = 10'(100 + i); mi1 = 10'(200 + i); mi2 = 10'(300 + i);
         tick();
         chk("bp.out_valid", 32'(out_valid), 1);
         chk("bp.in_ready", 32'(in_ready), 0);
         chk_sums("bp", 420, 780, 420);
      end
      in_valid = 1'b0;
      handshake();
      chk("bp.out_valid_drop", 32'(out_valid), 0);
      chk("bp.in_ready", 32'(in_ready), 1);
      chk("bp.frame_cnt", 32'(frame_cnt), 3);
      // counter untouched by held inputs: needs a full 8 accepts again
      send(7, 1, 1, 1);
      chk("bp.cnt_7", 32'(out_valid), 0);
      send(1, 1, 1, 1);
      chk("bp.cnt_8", 32'(out_valid), 1);
      chk_sums("bp.next", 8, 8, 8);
      handshake();

      // input gaps
      for (int i = 0; i < 15; i++) begin
         in_valid = (i % 2 == 0);
         mi0 = 10'd1; mi1 = 10'd2; mi2 = 10'd3;
         tick();
         if (i == 13) chk("gap.after7", 32'(out_valid), 0);
      end
      in_valid = 1'b0;
      chk("gap.out_valid", 32'(out_valid), 1);
      chk_sums("gap", 8, 16, 24);
      handshake();

      // reset mid-frame
      send(5, 10, 10, 10);
      reset = 1'b1;
      tick();
      chk("rstmid.in_ready", 32'(in_ready), 0);
      reset = 1'b0;
      #1;
      chk("rstmid.frame_cnt", 32'(frame_cnt), 0);
      chk_sums("rstmid.clr", 0, 0, 0);
      send(7, 1, 1, 1);
      chk("rstmid.after7", 32'(out_valid), 0);
      send(1, 1, 1, 1);
      chk("rstmid.out_valid", 32'(out_valid), 1);
      chk_sums("rstmid", 8, 8, 8);
      chk("rstmid.fc_before", 32'(frame_cnt), 0);
      handshake();
      chk("rstmid.fc_after", 32'(frame_cnt), 1);

      // LEN=1: each accept is a frame
      begin
         int v [3][3] = '{'{7, 13, 5}, '{0, 0, 0}, '{1023, 1023, 1023}};
         for (int f = 0; f < 3; f++) begin
            in_valid1 = 1'b1;
            mj0 = 10'(v[f][0]); mj1 = 10'(v[f][1]); mj2 = 10'(v[f][2]);
            out_ready1 = 1'b1;
            tick();
            in_valid1 = 1'b0;
            chk("len1.out_valid", 32'(out_valid1), 1);
            chk("len1.so0", 32'(sp0), v[f][0]);
            chk("len1.so1", 32'(sp1), v[f][1]);
            chk("len1.so2", 32'(sp2), v[f][2]);
            tick();
            chk("len1.frame_cnt", 32'(frame_cnt1), f + 1);
         end
         out_ready1 = 1'b0;
      end

      // 256 handshakes wrap frame_cnt
      reset1 = 1'b1;
      tick();
      reset1 = 1'b0;
      out_ready1 = 1'b1;
      for (int k = 0; k < 256; k++) begin
         in_valid1 = 1'b1;
         mj0 = 10'(k); mj1 = 10'(k); mj2 = 10'(k);
         tick();
         in_valid1 = 1'b0;
         tick();
         if (k == 254) chk("wrap.fc255", 32'(frame_cnt1), 255);
      end
      out_ready1 = 1'b0;
      chk("wrap.fc0", 32'(frame_cnt1), 0);
      chk("wrap.last_so0", 32'(sp0), 255);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
